// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtract path: FSM encoding,
// default operand width and the signed-overflow rule.
package sub_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Subtraction overflows only when the operand signs differ and the
   // result sign disagrees with the minuend.
   function automatic logic sub_overflow(input logic a_msb,
                                         input logic b_msb,
                                         input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell, the borrow-chain twin of the
// full_adder cell used by the ripple adders.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one bit per clock, LSB first,
// start/busy/done handshake with borrow, overflow and zero flags.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int                 CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_r;
   logic [WIDTH-1:0]   a_sr_r;
   logic [WIDTH-1:0]   b_sr_r;
   logic [WIDTH-2:0]   r_sr_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               borrow_r;
   logic               a_msb_r;
   logic               b_msb_r;
   logic [WIDTH-1:0]   diff_r;
   logic               borrow_out_r;
   logic               overflow_r;
   logic               zero_r;
   logic               ready_r;
   logic               busy_r;
   logic               done_r;

   logic               d_s;
   logic               bout_s;
   logic [WIDTH-1:0]   r_next_s;

   full_subtractor u_cell (
      .a    (a_sr_r[0]),
      .b    (b_sr_r[0]),
      .bin  (borrow_r),
      .d    (d_s),
      .bout (bout_s)
   );

   // The partial result keeps only WIDTH-1 bits; the newest bit enters at the top.
   assign r_next_s = {d_s, r_sr_r};

   // Control FSM, datapath shift registers and registered result/flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         a_sr_r       <= {WIDTH{1'b0}};
         b_sr_r       <= {WIDTH{1'b0}};
         r_sr_r       <= {(WIDTH-1){1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         borrow_r     <= 1'b0;
         a_msb_r      <= 1'b0;
         b_msb_r      <= 1'b0;
         diff_r       <= {WIDTH{1'b0}};
         borrow_out_r <= 1'b0;
         overflow_r   <= 1'b0;
         zero_r       <= 1'b0;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_sr_r   <= a;
                  b_sr_r   <= b;
                  a_msb_r  <= a[WIDTH-1];
                  b_msb_r  <= b[WIDTH-1];
                  borrow_r <= 1'b0;
                  cnt_r    <= {CNT_W{1'b0}};
                  state_r  <= SHIFT;
                  ready_r  <= 1'b0;
                  busy_r   <= 1'b1;
               end
            end
            SHIFT: begin
               a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
               b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
               r_sr_r   <= r_next_s[WIDTH-1:1];
               borrow_r <= bout_s;
               cnt_r    <= cnt_r + CNT_W'(1);
               // Last bit: publish the result from the cell outputs on this edge.
               if (cnt_r == LAST_CNT) begin
                  diff_r       <= r_next_s;
                  borrow_out_r <= bout_s;
                  overflow_r   <= sub_overflow(a_msb_r, b_msb_r, r_next_s[WIDTH-1]);
                  zero_r       <= (r_next_s == {WIDTH{1'b0}});
                  state_r      <= DONE;
                  busy_r       <= 1'b0;
                  done_r       <= 1'b1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign ready      = ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign diff       = diff_r;
   assign borrow_out = borrow_out_r;
   assign overflow   = overflow_r;
   assign zero       = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=32.
module tb_serial_subtractor;

   logic        clk;
   logic        rst;
   logic        start4, start32;
   logic [3:0]  a4, b4;
   logic [31:0] a32, b32;
   logic        ready4, busy4, done4, bo4, ov4, z4;
   logic [3:0]  diff4;
   logic        ready32, busy32, done32, bo32, ov32, z32;
   logic [31:0] diff32;

   int errors = 0;
   int checks = 0;
   int sel    = 4;
   int cyc;

   logic [31:0] o_diff;
   logic        o_ready, o_busy, o_done, o_bo, o_ov, o_z;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .ready(ready4), .busy(busy4), .done(done4), .diff(diff4),
      .borrow_out(bo4), .overflow(ov4), .zero(z4)
   );

   serial_subtractor #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
      .ready(ready32), .busy(busy32), .done(done32), .diff(diff32),
      .borrow_out(bo32), .overflow(ov32), .zero(z32)
   );

   assign o_diff  = (sel == 4) ? {28'd0, diff4} : diff32;
   assign o_ready = (sel == 4) ? ready4 : ready32;
   assign o_busy  = (sel == 4) ? busy4  : busy32;
   assign o_done  = (sel == 4) ? done4  : done32;
   assign o_bo    = (sel == 4) ? bo4    : bo32;
   assign o_ov    = (sel == 4) ? ov4    : ov32;
   assign o_z     = (sel == 4) ? z4     : z32;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic s, input logic [31:0] av, input logic [31:0] bv);
      if (sel == 4) begin
         start4 = s; a4 = av[3:0]; b4 = bv[3:0];
      end else begin
         start32 = s; a32 = av; b32 = bv;
      end
   endtask

   // Waits (bounded) for done; the cycle number of the first done is returned in cyc.
   task automatic wait_done(input int limit);
      while (!o_done && cyc < limit) tick();
   endtask

   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ed, input logic eb, input logic eo,
                         input logic ez, input string tag);
      sel = w;
      cyc = 0;
      drive(1'b1, av, bv);
      tick();
      drive(1'b0, ~av, ~bv);
      check({tag, ".busy"}, {63'd0, o_busy}, 64'd1);
      wait_done(200);
      check({tag, ".done_cycle"}, 64'(cyc), 64'(w + 1));
      check({tag, ".diff"}, {32'd0, o_diff}, {32'd0, ed});
      check({tag, ".borrow"}, {63'd0, o_bo}, {63'd0, eb});
      check({tag, ".ovf"}, {63'd0, o_ov}, {63'd0, eo});
      check({tag, ".zero"}, {63'd0, o_z}, {63'd0, ez});
      tick();
      check({tag, ".done_pulse"}, {63'd0, o_done}, 64'd0);
      check({tag, ".ready_back"}, {63'd0, o_ready}, 64'd1);
      check({tag, ".diff_hold"}, {32'd0, o_diff}, {32'd0, ed});
   endtask

   initial begin
      rst = 1'b1; start4 = 1'b0; start32 = 1'b0;
      a4 = 4'd0; b4 = 4'd0; a32 = 32'd0; b32 = 32'd0;
      #1;
      check("rst.ready4", {63'd0, ready4}, 64'd1);
      check("rst.busy4", {63'd0, busy4}, 64'd0);
      check("rst.done32", {63'd0, done32}, 64'd0);
      check("rst.diff32", {32'd0, diff32}, 64'd0);
      check("rst.zero32", {63'd0, z32}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      run_op(4, 32'h7, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, "w4_7m3");
      run_op(4, 32'h0, 32'h1, 32'hF, 1'b1, 1'b0, 1'b0, "w4_0m1");
      run_op(4, 32'h8, 32'h1, 32'h7, 1'b0, 1'b1, 1'b0, "w4_m8m1");
      run_op(4, 32'h7, 32'hF, 32'h8, 1'b1, 1'b1, 1'b0, "w4_7mneg1");
      run_op(4, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 1'b1, "w4_eq");
      run_op(32, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, "w32_eq");

      // Starts during SHIFT (cycle 5) and DONE (cycle 33) must be ignored.
      sel = 32;
      cyc = 0;
      drive(1'b1, 32'h12345678, 32'h11111111);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      while (cyc < 5) tick();
      drive(1'b1, 32'h0, 32'h1);
      tick();
      drive(1'b0, 32'h0, 32'h1);
      while (cyc < 20) tick();
      check("ign.diff_during_shift", {32'd0, o_diff}, {32'd0, 32'hDEADBEEF ^ 32'hDEADBEEF});
      wait_done(200);
      check("ign.done_cycle", 64'(cyc), 64'd33);
      check("ign.diff", {32'd0, o_diff}, 64'h01234567);
      drive(1'b1, 32'hFFFFFFFF, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      check("ign.ready34", {63'd0, o_ready}, 64'd1);
      repeat (3) tick();
      check("ign.no_restart_busy", {63'd0, o_busy}, 64'd0);
      check("ign.no_second_done", {63'd0, o_done}, 64'd0);
      check("ign.diff_held", {32'd0, o_diff}, 64'h01234567);

      // New operation: old result holds through SHIFT, then updates.
      cyc = 0;
      drive(1'b1, 32'd5, 32'd3);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      while (cyc < 10) tick();
      check("hold.mid_shift", {32'd0, o_diff}, 64'h01234567);
      wait_done(200);
      check("hold.done_cycle", 64'(cyc), 64'd33);
      check("hold.new_diff", {32'd0, o_diff}, 64'd2);

      // Reset in cycle 10 of a 32-bit operation.
      tick();
      cyc = 0;
      drive(1'b1, 32'hFFFFFFFF, 32'h1);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      while (cyc < 10) tick();
      rst = 1'b1;
      #1;
      check("arst.diff", {32'd0, o_diff}, 64'd0);
      check("arst.busy", {63'd0, o_busy}, 64'd0);
      check("arst.ready", {63'd0, o_ready}, 64'd1);
      repeat (2) tick();
      rst = 1'b0;
      cyc = 0;
      while (!o_done && cyc < 40) tick();
      check("arst.no_done", {63'd0, o_done}, 64'd0);
      check("arst.ready_after", {63'd0, o_ready}, 64'd1);
      run_op(32, 32'h00000010, 32'h00000020, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, "arst_next");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor: diff = a - b.
- Processes one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop.
- Serves as the subtract path next to the ripple adders in the ALU datapath when area matters more than latency.
- Uses a start/busy/done handshake and produces borrow, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only while ready=1
- a  input  WIDTH  minuend, sampled on the accept cycle only
- b  input  WIDTH  subtrahend, sampled on the accept cycle only
- ready  output  1  high in IDLE
- busy  output  1  high in SHIFT
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow_out  output  1  1 when unsigned a < b
- overflow  output  1  signed overflow of a - b
- zero  output  1  1 when diff == 0

Behaviour:
- Reset (async, immediate):
  - state = IDLE; shift registers, counter and borrow FF = 0.
  - diff = 0, borrow_out = 0, overflow = 0, zero = 0.
  - ready = 1, busy = 0, done = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready = 1.
  - On start = 1: load a_sr <= a, b_sr <= b, borrow <= 0, cnt <= 0; go to SHIFT.
  - On start = 0: stay in IDLE.
- SHIFT (busy = 1), each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - a_sr and b_sr shift right by one.
  - r_sr <= {d, r_sr[WIDTH-1:1]}.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - done = 1.
  - diff, borrow_out, overflow and zero are registered from the final r_sr/borrow; all four update on the same edge.
  - overflow = (a_msb != b_msb) && (diff_msb != a_msb); a_msb and b_msb are captured at accept.
  - Next state is IDLE unconditionally.
- Latency:
  - Accept edge at cycle 0; done is high during cycle WIDTH+1.
  - ready returns in cycle WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- Result outputs hold their values from done until the next done. They do not change at accept or during SHIFT.
- start while busy or in DONE: ignored, with no queueing; a, b and the in-flight result are unaffected.
- start held high continuously: a new operation is accepted in every IDLE cycle.
- Operand changes after the accept cycle have no effect.
- Reset mid-operation: aborts immediately, no done pulse, result outputs return to reset values.
- Arithmetic: modulo 2^WIDTH. borrow_out is the final borrow FF, i.e. the inverted carry of a + ~b + 1.
- Edge cases:
  - a == b gives diff = 0, zero = 1, borrow_out = 0.
  - 0 - 1 gives all-ones, borrow_out = 1.

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, SHIFT, DONE} with 2-bit encoding.
  - Default WIDTH constant, so ALU instances and benches agree.
- One natural sub-module: full_subtractor.
  - Combinational 1-bit cell: inputs a, b, bin; outputs d, bout.
  - Mirrors the existing full_adder cell and is instantiated once.

Test Plan:
- Reset then WIDTH=4, a=7, b=3, start one cycle: done in cycle 5, diff=4, borrow_out=0, overflow=0, zero=0; ready back in cycle 6.
- WIDTH=4, a=0, b=1: diff=0xF, borrow_out=1, overflow=0, zero=0.
- WIDTH=4, a=0x8 (-8), b=0x1: diff=0x7, overflow=1, borrow_out=0. Also a=0x7, b=0xF (-1): diff=0x8, overflow=1, borrow_out=1.
- WIDTH=32, a=b=0xDEADBEEF: done in cycle 33, diff=0, zero=1, borrow_out=0, overflow=0.
- WIDTH=32, start pulsed again in cycles 5 and 33 with different operands: both ignored; a single done with the original result; diff holds after done until the next accepted operation completes.
- rst asserted in cycle 10 of a 32-bit operation: outputs zero asynchronously, no done pulse, ready=1 after release; the next start completes normally.
